id_decode_stage: RTL and testbench



---
 rtl/id_pkg.sv | 34 +++
 rtl/id_register_file.sv | 42 ++++
 rtl/id_decode_stage.sv | 174 +++++++++++++++++
 tb/tb_id_decode_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op encodings and
// the control bundle handed to execute.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // Field order is the ex_ctrl bit order, MSB first.
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_register_file.sv
// 2-read/1-write register file with r0 hardwired to zero.
// ID_WB_BYPASS_EN: a same-cycle write is forwarded to the read ports.
module id_register_file
  import id_pkg::*;
#(
  parameter int width_B   = 32,
  parameter int RegAddr_B = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RegAddr_B-1:0] rs_addr_i,
  input  logic [RegAddr_B-1:0] rt_addr_i,
  output logic [width_B-1:0]   rs_data_o,
  output logic [width_B-1:0]   rt_data_o,
  input  logic                 we_i,
  input  logic [RegAddr_B-1:0] waddr_i,
  input  logic [width_B-1:0]   wdata_i
);

  localparam int NumRegs = 1 << RegAddr_B;

  logic [width_B-1:0] regs_q [NumRegs];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rs_data_o = (rs_addr_i == '0) ? '0 :
                     (we_i && waddr_i == rs_addr_i) ? wdata_i : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == '0) ? '0 :
                     (we_i && waddr_i == rt_addr_i) ? wdata_i : regs_q[rt_addr_i];
`else
  assign rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`endif

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: IF/ID register, register read, control decode, load-use stall
// and the ID/EX register. ID_WB_BYPASS_EN enables register-file write-through.
module id_decode_stage
  import id_pkg::*;
#(
  parameter int width_B   = 32,
  parameter int RegAddr_B = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [width_B-1:0]   if_instr,
  input  logic [width_B-1:0]   if_pc_plus1,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [RegAddr_B-1:0] wb_addr,
  input  logic [width_B-1:0]   wb_data,
  output logic                 pc_write,
  output logic                 ex_valid,
  output logic [width_B-1:0]   ex_rs_data,
  output logic [width_B-1:0]   ex_rt_data,
  output logic [width_B-1:0]   ex_imm,
  output logic [RegAddr_B-1:0] ex_rs,
  output logic [RegAddr_B-1:0] ex_rt,
  output logic [RegAddr_B-1:0] ex_rd,
  output logic [width_B-1:0]   ex_pc_plus1,
  output logic [25:0]          ex_jaddr,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 illegal_instr
);

  typedef struct packed {
    logic               valid;
    logic [width_B-1:0] instr;
    logic [width_B-1:0] pc_plus1;
  } ifid_t;

  typedef struct packed {
    logic                 valid;
    logic [width_B-1:0]   rs_data;
    logic [width_B-1:0]   rt_data;
    logic [width_B-1:0]   imm;
    logic [RegAddr_B-1:0] rs;
    logic [RegAddr_B-1:0] rt;
    logic [RegAddr_B-1:0] rd;
    logic [width_B-1:0]   pc_plus1;
    logic [25:0]          jaddr;
    ctrl_t                ctrl;
    logic                 illegal;
  } idex_t;

  ifid_t ifid_q, ifid_d;
  idex_t idex_q, idex_d;

  logic [5:0]           opcode;
  logic [RegAddr_B-1:0] rs, rt, rd;
  logic [width_B-1:0]   rs_data, rt_data;
  ctrl_t                dec_ctrl;
  logic                 dec_illegal;
  logic                 rt_used;
  logic                 stall;

  assign opcode = ifid_q.instr[31:26];
  assign rs     = ifid_q.instr[21 +: RegAddr_B];
  assign rt     = ifid_q.instr[16 +: RegAddr_B];
  assign rd     = ifid_q.instr[11 +: RegAddr_B];

  id_register_file #(
    .width_B  (width_B),
    .RegAddr_B(RegAddr_B)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr_i(rs),
    .rt_addr_i(rt),
    .rs_data_o(rs_data),
    .rt_data_o(rt_data),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data)
  );

  always_comb begin
    dec_ctrl    = CTRL_BUBBLE;
    dec_illegal = 1'b0;
    rt_used     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_FUNCT;
        rt_used            = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        rt_used            = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        rt_used         = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_J:    dec_ctrl.jump = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  assign stall = idex_q.valid & idex_q.ctrl.mem_read & (idex_q.rt != '0) &
                 ((idex_q.rt == rs) | ((idex_q.rt == rt) & rt_used));

  assign pc_write = flush | ~stall;

  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d = '0;
    end else if (!stall) begin
      ifid_d.valid    = 1'b1;
      ifid_d.instr    = if_instr;
      ifid_d.pc_plus1 = if_pc_plus1;
    end
  end

  always_comb begin
    idex_d = '0;
    if (!flush && !stall) begin
      idex_d.valid    = ifid_q.valid;
      idex_d.rs_data  = rs_data;
      idex_d.rt_data  = rt_data;
      idex_d.imm      = {{(width_B-16){ifid_q.instr[15]}}, ifid_q.instr[15:0]};
      idex_d.rs       = rs;
      idex_d.rt       = rt;
      idex_d.rd       = rd;
      idex_d.pc_plus1 = ifid_q.pc_plus1;
      idex_d.jaddr    = ifid_q.instr[25:0];
      idex_d.ctrl     = ifid_q.valid ? dec_ctrl : CTRL_BUBBLE;
      idex_d.illegal  = ifid_q.valid & dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  assign ex_valid      = idex_q.valid;
  assign ex_rs_data    = idex_q.rs_data;
  assign ex_rt_data    = idex_q.rt_data;
  assign ex_imm        = idex_q.imm;
  assign ex_rs         = idex_q.rs;
  assign ex_rt         = idex_q.rt;
  assign ex_rd         = idex_q.rd;
  assign ex_pc_plus1   = idex_q.pc_plus1;
  assign ex_jaddr      = idex_q.jaddr;
  assign ex_ctrl       = idex_q.ctrl;
  assign illegal_instr = idex_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: an instruction-level reference model
// predicts every ID/EX issue; a negedge monitor compares what the DUT presents.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_instr, if_pc_plus1;
  logic        flush, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_write, ex_valid, illegal_instr;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus1;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [25:0] ex_jaddr;
  logic [9:0]  ex_ctrl;

  always #5 clk = ~clk;

  id_decode_stage #(.width_B(32), .RegAddr_B(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc_plus1(if_pc_plus1),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_write(pc_write), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_pc_plus1(ex_pc_plus1), .ex_jaddr(ex_jaddr),
    .ex_ctrl(ex_ctrl), .illegal_instr(illegal_instr)
  );

  typedef struct packed {
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc1;
    logic [25:0] jaddr;
    logic [9:0]  ctrl;
    logic        illegal;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pcCount = 0;

  // Reference model: architectural registers plus which instruction sits in ID and EX.
  logic [31:0] mRegs [32];
  logic        mIdValid = 1'b0;
  logic [31:0] mIdInstr = '0;
  logic [31:0] mIdPc = '0;
  logic        mExValid = 1'b0;
  logic        mExIsLoad = 1'b0;
  logic [4:0]  mExRt = '0;

  function automatic logic [9:0] ctrlFor(input logic [5:0] op);
    case (op)
      6'h00:   return 10'b1000010010;
      6'h23:   return 10'b0110110000;
      6'h2B:   return 10'b0101000000;
      6'h04:   return 10'b0000001001;
      6'h08:   return 10'b0100010000;
      6'h02:   return 10'b0000000100;
      default: return 10'b0000000000;
    endcase
  endfunction

  function automatic bit isKnown(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h08 || op == 6'h02;
  endfunction

  function automatic bit readsRt(input logic [5:0] op);
    return op == 6'h00 || op == 6'h2B || op == 6'h04;
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mRegs[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; the model predicts pc_write and the next ID/EX content.
  task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic fl,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               output bit accepted);
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit         stall;
    exp_t       e;
    rst_n = r; if_instr = instr; if_pc_plus1 = pcCount + 1; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    op = mIdInstr[31:26]; rs = mIdInstr[25:21]; rt = mIdInstr[20:16];
    stall = mExValid && mExIsLoad && mExRt != 5'd0 &&
            (mExRt == rs || (mExRt == rt && readsRt(op)));
    if (r) checkOutput("pc_write", {31'd0, pc_write}, {31'd0, fl || !stall});
    if (r && !fl && !stall && mIdValid) begin
      e.rsData = readReg(rs, we, wa, wd);
      e.rtData = readReg(rt, we, wa, wd);
      e.imm = {{16{mIdInstr[15]}}, mIdInstr[15:0]};
      e.rs = rs; e.rt = rt; e.rd = mIdInstr[15:11];
      e.pc1 = mIdPc; e.jaddr = mIdInstr[25:0];
      e.ctrl = ctrlFor(op); e.illegal = !isKnown(op);
      expQ.push_back(e);
    end
    @(posedge clk);
    accepted = 1'b1;
    if (!r) begin
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mIdValid = 0; mIdInstr = '0; mIdPc = '0; mExValid = 0; mExIsLoad = 0; mExRt = '0;
      pcCount = 0;
    end else begin
      if (fl) begin
        mExValid = 0; mExIsLoad = 0; mExRt = '0;
        mIdValid = 0; mIdInstr = '0; mIdPc = '0;
      end else if (stall) begin
        mExValid = 0; mExIsLoad = 0; mExRt = '0;
        accepted = 1'b0;
      end else begin
        mExValid = mIdValid; mExIsLoad = mIdValid && op == 6'h23; mExRt = rt;
        mIdValid = 1; mIdInstr = instr; mIdPc = pcCount + 1;
      end
      if (accepted) pcCount++;
      if (we && wa != 5'd0) mRegs[wa] = wd;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] instr, output int stallsSeen);
    bit acc;
    stallsSeen = 0;
    for (int t = 0; t < 4; t++) begin
      if (pc_write === 1'b0) stallsSeen++;
      applyStimulus(1'b1, instr, 1'b0, 1'b0, 5'd0, 32'd0, acc);
      if (acc) return;
    end
    vectors++;
    miscompares++;
    $display("[TB] FAIL issue_timeout instr %h not accepted within 4 cycles", instr);
  endtask

  // Monitor: every instruction the DUT issues must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t act, exp;
    if (ex_valid === 1'b1) begin
      act = {ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_pc_plus1,
             ex_jaddr, ex_ctrl, illegal_instr};
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_issue got %h expected no issue", act);
      end else begin
        exp = expQ.pop_front();
        if (act !== exp) begin
          miscompares++;
          $display("[TB] FAIL ex_bundle got %h expected %h", act, exp);
        end
      end
    end else if (illegal_instr !== 1'b0 && $time > 20) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL illegal_on_bubble got %b expected 0", illegal_instr);
    end
  end

  initial begin
    bit          acc;
    int          stalls;
    logic [31:0] instr;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) mRegs[i] = '0;

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h1234, acc);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    checkOutput("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_ex_ctrl", {22'd0, ex_ctrl}, 32'd0);
    checkOutput("reset_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("reset_illegal", {31'd0, illegal_instr}, 32'd0);
    checkOutput("reset_ex_rs_data", ex_rs_data, 32'd0);

    $display("[TB] directed: addi after writeback");
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b1, 5'd1, 32'd5, acc);
    issue(32'h20220003, stalls);
    issue(32'h0, stalls);
    checkOutput("addi_rs_data", ex_rs_data, 32'd5);
    checkOutput("addi_ctrl", {22'd0, ex_ctrl}, 32'h110);

    $display("[TB] directed: load-use stall");
    issue(32'h8C230000, stalls);
    issue(32'h00612020, stalls);
    issue(32'h0, stalls);
    checkOutput("load_use_stall_cycles", stalls, 32'd1);
    issue(32'h0, stalls);

    $display("[TB] directed: flush during stall");
    issue(32'h8C230000, stalls);
    issue(32'h00612020, stalls);
    checkOutput("stall_before_flush", {31'd0, pc_write}, 32'd0);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
    checkOutput("flush_bubble_valid", {31'd0, ex_valid}, 32'd0);
    issue(32'h0, stalls);

    $display("[TB] directed: writeback same cycle as decode");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 5'd7, 32'h11111111, acc);
    issue(32'h00E04020, stalls);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, acc);
    issue(32'h00004820, stalls);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, acc);

    $display("[TB] directed: illegal opcode");
    issue(32'hFC000000, stalls);
    issue(32'h0, stalls);
    checkOutput("illegal_pulse", {31'd0, illegal_instr}, 32'd1);
    issue(32'h0, stalls);
    checkOutput("illegal_pulse_end", {31'd0, illegal_instr}, 32'd0);

    $display("[TB] random phase");
    acc = 1'b1;
    instr = '0;
    for (int n = 0; n < 600; n++) begin
      if (acc) begin
        case ($urandom_range(0, 7))
          0: op = 6'h00;
          1: op = 6'h23;
          2: op = 6'h2B;
          3: op = 6'h04;
          4: op = 6'h08;
          5: op = 6'h02;
          6: op = 6'h3F;
          default: op = 6'($urandom_range(0, 63));
        endcase
        instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      end
      applyStimulus(($urandom_range(0, 99) != 0), instr, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), $urandom, acc);
    end

    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
    #2;
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
